// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared pipeline definitions for the instruction-fetch stage
//
// Contents:
//   fetch_state_t     fetch controller states (REQ / WAIT / VALID)
//   NOP               bubble presented to IF/ID while no instruction is held
//   DEFAULT_RESET_PC  default PC after reset
//   word_align()      clears the two low address bits

package if_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_REQ   = 2'd0,
      FETCH_WAIT  = 2'd1,
      FETCH_VALID = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Instruction addresses are always word aligned, so any low bits on
   // an incoming target are discarded rather than trusted.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - MIPS instruction-fetch stage: PC register and instruction-memory port
//
// Ports:
//   clk              pipeline clock, rising edge
//   reset            asynchronous active-high reset
//   Stall            hazard-unit hold (same signal that holds IF/ID)
//   Redirect         taken branch/jump resolved in ID this cycle
//   Redirect_Target  new PC when Redirect=1 (low two bits ignored)
//   inst_req         instruction-memory request valid
//   inst_addr        request address (= PC)
//   inst_addr_ok     request accepted this cycle
//   inst_data_ok     read data returned this cycle
//   inst_rdata       read data, valid with inst_data_ok
//   IF_PC_plus_4     PC+4 of the presented instruction
//   IF_Instruction   fetched instruction, NOP when IF_Valid=0
//   IF_Valid         IF_Instruction holds a real instruction
//   Fetch_Stall      inverse of IF_Valid, to the hazard unit

module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] Redirect_Target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] IF_PC_plus_4,
   output logic [31:0] IF_Instruction,
   output logic        IF_Valid,
   output logic        Fetch_Stall
);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [31:0]  pc;
   logic [31:0]  pc_next;
   logic [31:0]  inst_buf;
   logic [31:0]  inst_buf_next;
   // Set when the outstanding read belongs to a PC that has since been
   // redirected away from; its data must be swallowed when it arrives.
   logic         drop;
   logic         drop_next;
   logic [31:0]  target;

   assign target = word_align(Redirect_Target);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= FETCH_REQ;
         pc       <= RESET_PC;
         inst_buf <= NOP;
         drop     <= 1'b0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         inst_buf <= inst_buf_next;
         drop     <= drop_next;
      end
   end

   // Next-state logic. Redirect outranks Stall everywhere; Stall only
   // matters once an instruction is being presented.
   always_comb begin
      state_next    = state;
      pc_next       = pc;
      inst_buf_next = inst_buf;
      drop_next     = drop;
      case (state)
         FETCH_REQ: begin
            if (Redirect) begin
               pc_next = target;
            end
            if (inst_addr_ok) begin
               state_next = FETCH_WAIT;
               // The accepted request was for the old PC when redirecting.
               drop_next  = Redirect;
            end
         end
         FETCH_WAIT: begin
            if (inst_data_ok) begin
               state_next = FETCH_REQ;
               drop_next  = 1'b0;
               if (Redirect) begin
                  pc_next = target;
               end else if (!drop) begin
                  inst_buf_next = inst_rdata;
                  state_next    = FETCH_VALID;
               end
            end else if (Redirect) begin
               pc_next   = target;
               drop_next = 1'b1;
            end
         end
         FETCH_VALID: begin
            if (Redirect) begin
               pc_next    = target;
               state_next = FETCH_REQ;
            end else if (!Stall) begin
               pc_next    = pc + 32'd4;
               state_next = FETCH_REQ;
            end
         end
         default: begin
            state_next = FETCH_REQ;
            drop_next  = 1'b0;
         end
      endcase
   end

   // Output decode: purely from registered state, so memory read data
   // never reaches IF_Instruction combinationally.
   always_comb begin
      inst_req       = 1'b0;
      inst_addr      = pc;
      IF_PC_plus_4   = pc + 32'd4;
      IF_Valid       = 1'b0;
      IF_Instruction = NOP;
      case (state)
         FETCH_REQ: begin
            inst_req = 1'b1;
         end
         FETCH_VALID: begin
            IF_Valid       = 1'b1;
            IF_Instruction = inst_buf;
         end
         default: begin
            inst_req = 1'b0;
         end
      endcase
      Fetch_Stall = ~IF_Valid;
   end

endmodule
